// File: rtl/resolution_overlay_ctrl.sv
// Glyph-ROM sequencer: prefetches one ROM line per raster row and serialises it MSB first into an overlay pixel.
// Optional macro RES_OVL_CHANGE_HOLD_EN suppresses the overlay for HOLD_FRAMES frames after a mode change.
`ifndef RESLINE_SIZE
`define RESLINE_SIZE 8
`endif

module resolution_overlay_ctrl #(
  parameter int LINE_W      = `RESLINE_SIZE,
  parameter int CNT_W       = 12,
  parameter int MODE_W      = 4,
  parameter int X_START     = 32,
  parameter int Y_START     = 32,
  parameter int SCALE_LOG2  = 0,
  parameter int HOLD_FRAMES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  xpos,
  input  logic [CNT_W-1:0]  ypos,
  input  logic [MODE_W-1:0] mode_id_in,
  output logic [MODE_W-1:0] rom_mode_id,
  output logic [3:0]        rom_addr,
  input  logic [LINE_W-1:0] rom_q,
  output logic              ovl_active,
  output logic              ovl_px
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

  localparam int               BIT_W    = $clog2(LINE_W + 1);
  localparam logic [CNT_W-1:0] X_TRIG   = CNT_W'(X_START - 3);
  localparam logic [CNT_W-1:0] Y_FIRST  = CNT_W'(Y_START);
  localparam logic [2:0]       REP_LAST = 3'((1 << SCALE_LOG2) - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LINE_W - 1);

  state_t            state, state_nxt;
  logic [LINE_W-1:0] sreg, sreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        rep_cnt, rep_cnt_nxt;
  logic [3:0]        rom_addr_nxt;
  logic              active_nxt, px_nxt;
  logic [CNT_W-1:0]  xpos_prev, row_off, glyph_row;
  logic              in_box, x_back, in_flight, suppress;

  assign row_off   = ypos - Y_FIRST;
  assign glyph_row = row_off >> SCALE_LOG2;
  assign in_box    = (ypos >= Y_FIRST) && (glyph_row < CNT_W'(16));
  // A falling column count means the raster restarted the line under us
  assign x_back    = xpos < xpos_prev;
  assign in_flight = (state == FETCH) || (state == LOAD) || (state == SHIFT);

`ifdef RES_OVL_CHANGE_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (frame_start) begin
      if (mode_id_in != rom_mode_id)
        hold_cnt <= HOLD_W'(HOLD_FRAMES);
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign suppress = (hold_cnt != '0);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    bit_cnt_nxt  = bit_cnt;
    rep_cnt_nxt  = rep_cnt;
    rom_addr_nxt = rom_addr;
    active_nxt   = 1'b0;
    px_nxt       = 1'b0;
    if (frame_start) begin
      state_nxt = IDLE;
    end else if (x_back && in_flight) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if ((xpos == X_TRIG) && in_box) begin
            rom_addr_nxt = glyph_row[3:0];
            state_nxt    = FETCH;
          end
        end
        FETCH: state_nxt = LOAD;
        LOAD: begin
          sreg_nxt    = rom_q;
          bit_cnt_nxt = '0;
          rep_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
        SHIFT: begin
          active_nxt = 1'b1;
          px_nxt     = sreg[LINE_W-1];
          // Each glyph bit is replicated until the repeat counter wraps
          if (rep_cnt == REP_LAST) begin
            rep_cnt_nxt = '0;
            sreg_nxt    = sreg << 1;
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST)
              state_nxt = DONE;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        DONE: begin
          if (xpos < X_TRIG)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      rom_addr    <= '0;
      rom_mode_id <= '0;
      ovl_active  <= 1'b0;
      ovl_px      <= 1'b0;
      xpos_prev   <= '0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      rep_cnt    <= rep_cnt_nxt;
      rom_addr   <= rom_addr_nxt;
      ovl_active <= active_nxt && !suppress;
      ovl_px     <= px_nxt && !suppress;
      xpos_prev  <= xpos;
      if (frame_start)
        rom_mode_id <= mode_id_in;
    end
  end

endmodule

// File: tb/tb_resolution_overlay_ctrl.sv
// Bench for resolution_overlay_ctrl: unscaled and 2x-scaled instances share one raster and a registered ROM model.
module tb_resolution_overlay_ctrl;

  localparam int LW = 8;

`ifdef RES_OVL_CHANGE_HOLD_EN
  localparam int HOLD_ON = 1;
`else
  localparam int HOLD_ON = 0;
`endif

  typedef struct {
    int         x;
    int         y;
    logic       fs;
    logic       act0;
    logic       px0;
    logic [3:0] addr0;
    logic       act1;
    logic       px1;
    logic [3:0] addr1;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [11:0]   xpos = '0;
  logic [11:0]   ypos = '0;
  logic [3:0]    mode_id_in = '0;
  logic [3:0]    rom_mode_id0, rom_mode_id1, rom_addr0, rom_addr1;
  logic [LW-1:0] rom_q0 = '0;
  logic [LW-1:0] rom_q1 = '0;
  logic          act0, px0, act1, px1;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  int   seg_a;
  logic [3:0] prev0 = '0;
  logic [3:0] prev1 = '0;

  always #5 clock = ~clock;

  resolution_overlay_ctrl #(
    .LINE_W(LW), .CNT_W(12), .MODE_W(4), .X_START(32), .Y_START(32),
    .SCALE_LOG2(0), .HOLD_FRAMES(2)
  ) dut0 (
    .clock(clock), .reset(reset), .frame_start(frame_start), .xpos(xpos), .ypos(ypos),
    .mode_id_in(mode_id_in), .rom_mode_id(rom_mode_id0), .rom_addr(rom_addr0),
    .rom_q(rom_q0), .ovl_active(act0), .ovl_px(px0)
  );

  resolution_overlay_ctrl #(
    .LINE_W(LW), .CNT_W(12), .MODE_W(4), .X_START(32), .Y_START(32),
    .SCALE_LOG2(1), .HOLD_FRAMES(2)
  ) dut1 (
    .clock(clock), .reset(reset), .frame_start(frame_start), .xpos(xpos), .ypos(ypos),
    .mode_id_in(mode_id_in), .rom_mode_id(rom_mode_id1), .rom_addr(rom_addr1),
    .rom_q(rom_q1), .ovl_active(act1), .ovl_px(px1)
  );

  function automatic logic [LW-1:0] rom_line(input logic [3:0] a);
    if (a == 4'd0) return 8'hAA;
    return {a, ~a};
  endfunction

  // Registered glyph ROM: data follows the address by one clock
  always @(posedge clock) begin
    rom_q0 <= rom_line(rom_addr0);
    rom_q1 <= rom_line(rom_addr1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_fs();
    vec_t v;
    v.x = 0; v.y = 0; v.fs = 1'b1;
    v.act0 = 1'b0; v.px0 = 1'b0; v.addr0 = prev0;
    v.act1 = 1'b0; v.px1 = 1'b0; v.addr1 = prev1;
    vecs.push_back(v);
  endtask

  task automatic add_line(input int y, input int x0, input int x1);
    vec_t v;
    logic [LW-1:0] ln;
    bit in0, in1;
    int g0, g1;
    in0 = (y >= 32) && ((y - 32) < 16);
    in1 = (y >= 32) && (((y - 32) >> 1) < 16);
    g0 = y - 32;
    g1 = (y - 32) >>> 1;
    for (int x = x0; x <= x1; x++) begin
      v.x = x; v.y = y; v.fs = 1'b0;
      if (in0 && x == 29) prev0 = 4'(g0);
      if (in1 && x == 29) prev1 = 4'(g1);
      v.addr0 = prev0;
      v.addr1 = prev1;
      v.act0 = in0 && x >= 32 && x < 32 + LW;
      v.act1 = in1 && x >= 32 && x < 32 + 2 * LW;
      v.px0 = 1'b0;
      v.px1 = 1'b0;
      if (v.act0) begin
        ln = rom_line(4'(g0));
        v.px0 = ln[LW - 1 - (x - 32)];
      end
      if (v.act1) begin
        ln = rom_line(4'(g1));
        v.px1 = ln[LW - 1 - ((x - 32) >> 1)];
      end
      vecs.push_back(v);
    end
  endtask

  task automatic drive_vec(input int x, input int y, input logic fs);
    @(negedge clock);
    xpos = 12'(x);
    ypos = 12'(y);
    frame_start = fs;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive_vec(v.x, v.y, v.fs);
  endtask

  task automatic checkOutput(input vec_t v);
    check($sformatf("act0 x=%0d y=%0d", v.x, v.y), 32'(act0), 32'(v.act0));
    check($sformatf("px0 x=%0d y=%0d", v.x, v.y), 32'(px0), 32'(v.px0));
    check($sformatf("addr0 x=%0d y=%0d", v.x, v.y), 32'(rom_addr0), 32'(v.addr0));
    check($sformatf("act1 x=%0d y=%0d", v.x, v.y), 32'(act1), 32'(v.act1));
    check($sformatf("px1 x=%0d y=%0d", v.x, v.y), 32'(px1), 32'(v.px1));
    check($sformatf("addr1 x=%0d y=%0d", v.x, v.y), 32'(rom_addr1), 32'(v.addr1));
  endtask

  // Sweeps one line on the unscaled instance, counting active cycles and wrong pixels
  task automatic run_line(input int y, output int act_cnt, output int px_err);
    logic [LW-1:0] ln;
    ln = rom_line(4'(y - 32));
    act_cnt = 0;
    px_err = 0;
    for (int x = 0; x < 50; x++) begin
      drive_vec(x, y, 1'b0);
      if (act0) begin
        act_cnt++;
        if (x < 32 || x >= 32 + LW) px_err++;
        else if (px0 !== ln[LW - 1 - (x - 32)]) px_err++;
      end
    end
  endtask

  initial begin
    int ac, pe;

    add_fs();
    add_line(47, 0, 49);
    add_line(48, 0, 49);
    add_line(32, 0, 49);
    add_line(31, 0, 49);
    add_line(35, 0, 49);
    add_line(34, 0, 34);
    add_line(35, 0, 49);
    seg_a = vecs.size();
    prev0 = '0;
    prev1 = '0;
    add_line(33, 0, 49);

    repeat (2) @(posedge clock);
    #1;
    check("reset act0", 32'(act0), 32'd0);
    check("reset px0", 32'(px0), 32'd0);
    check("reset addr0", 32'(rom_addr0), 32'd0);
    check("reset mode0", 32'(rom_mode_id0), 32'd0);
    check("reset act1", 32'(act1), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < seg_a; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Mode latch and optional post-change hold
    mode_id_in = 4'd3;
    drive_vec(0, 0, 1'b1);
    check("mode latch 3", 32'(rom_mode_id0), 32'd3);
    drive_vec(0, 0, 1'b1);
    drive_vec(0, 0, 1'b1);
    mode_id_in = 4'd5;
    run_line(32, ac, pe);
    check("mode stable midframe", 32'(rom_mode_id0), 32'd3);
    check("mode stable midframe dut1", 32'(rom_mode_id1), 32'd3);
    check("baseline active count", 32'(ac), 32'(LW));
    check("baseline px errors", 32'(pe), 32'd0);
    drive_vec(0, 0, 1'b1);
    check("mode latch 5", 32'(rom_mode_id0), 32'd5);
    run_line(32, ac, pe);
    check("frame1 active count", 32'(ac), 32'(HOLD_ON ? 0 : LW));
    drive_vec(0, 0, 1'b1);
    run_line(32, ac, pe);
    check("frame2 active count", 32'(ac), 32'(HOLD_ON ? 0 : LW));
    drive_vec(0, 0, 1'b1);
    run_line(32, ac, pe);
    check("frame3 active count", 32'(ac), 32'(LW));
    check("frame3 px errors", 32'(pe), 32'd0);

    // Reset asserted mid-SHIFT clears outputs without waiting for a clock
    for (int x = 0; x <= 34; x++) drive_vec(x, 32, 1'b0);
    check("pre-reset act0", 32'(act0), 32'd1);
    check("pre-reset act1", 32'(act1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset act0", 32'(act0), 32'd0);
    check("async reset px0", 32'(px0), 32'd0);
    check("async reset mode0", 32'(rom_mode_id0), 32'd0);
    check("async reset act1", 32'(act1), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = seg_a; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    frame_start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
